// File: rtl/hb_interp2.sv
// Halfband x2 interpolator: 27-tap halfband prototype in polyphase form, shift-add coefficients.
// One input accepted per 6 clocks; emits the interpolated point A, then the centre sample B.
module hb_interp2 #(
    parameter int unsigned DW   = 16,
    parameter int unsigned ACCW = 36
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] x_in,
    input  logic                 x_in_valid,
    output logic                 x_in_ready,
    output logic signed [DW-1:0] y_out,
    output logic                 y_out_valid
);

    typedef enum logic [2:0] {StIdle, StPair, StMult, StAcc, StOutA, StOutB} state_e;

    localparam logic signed [ACCW-1:0] YMax = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] YMin = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_e                 state_q, state_d;
    logic signed [DW-1:0]   d_q[14], d_d[14];
    logic signed [DW:0]     p_q[7], p_d[7];
    logic signed [DW-1:0]   ctr_q, ctr_d;
    logic signed [ACCW-1:0] prod_q[7], prod_d[7];
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [DW-1:0]   y_q, y_d;
    logic                   yv_q, yv_d;

    logic signed [ACCW-1:0] pe[7];
    logic signed [ACCW-1:0] m[7];
    logic signed [ACCW-1:0] acc_sum;
    logic signed [ACCW-1:0] sh;

    assign x_in_ready  = (state_q == StIdle);
    assign y_out       = y_q;
    assign y_out_valid = yv_q;

    always_comb begin
        for (int k = 0; k < 7; k++) begin
            pe[k] = $signed({{(ACCW-DW-1){p_q[k][DW]}}, p_q[k]});
        end
        // c0..c6 = 3, -25, 117, -394, 1078, -2753, 10165
        m[0] = (pe[0] <<< 1) + pe[0];
        m[1] = -((pe[1] <<< 4) + (pe[1] <<< 3) + pe[1]);
        m[2] = (pe[2] <<< 6) + (pe[2] <<< 5) + (pe[2] <<< 4) + (pe[2] <<< 2) + pe[2];
        m[3] = -((pe[3] <<< 8) + (pe[3] <<< 7) + (pe[3] <<< 3) + (pe[3] <<< 1));
        m[4] = (pe[4] <<< 10) + (pe[4] <<< 5) + (pe[4] <<< 4) + (pe[4] <<< 2) + (pe[4] <<< 1);
        m[5] = -((pe[5] <<< 11) + (pe[5] <<< 9) + (pe[5] <<< 7) + (pe[5] <<< 6) + pe[5]);
        m[6] = (pe[6] <<< 13) + (pe[6] <<< 10) + (pe[6] <<< 9) + (pe[6] <<< 8)
             + (pe[6] <<< 7) + (pe[6] <<< 5) + (pe[6] <<< 4) + (pe[6] <<< 2) + pe[6];

        acc_sum = '0;
        for (int k = 0; k < 7; k++) begin
            acc_sum = acc_sum + prod_q[k];
        end
        // >>>14 takes Q30 to Q15 and applies the interpolation gain of 2
        sh = acc_q >>> 14;
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        p_d     = p_q;
        ctr_d   = ctr_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        y_d     = y_q;
        yv_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (x_in_valid) begin
                    d_d[0] = x_in;
                    for (int k = 1; k < 14; k++) begin
                        d_d[k] = d_q[k-1];
                    end
                    state_d = StPair;
                end
            end
            StPair: begin
                for (int k = 0; k < 7; k++) begin
                    p_d[k] = $signed({d_q[k][DW-1], d_q[k]}) + $signed({d_q[13-k][DW-1], d_q[13-k]});
                end
                ctr_d   = d_q[6];
                state_d = StMult;
            end
            StMult: begin
                prod_d  = m;
                state_d = StAcc;
            end
            StAcc: begin
                acc_d   = acc_sum;
                state_d = StOutA;
            end
            StOutA: begin
                if (sh > YMax) begin
                    y_d = YMax[DW-1:0];
                end else if (sh < YMin) begin
                    y_d = YMin[DW-1:0];
                end else begin
                    y_d = sh[DW-1:0];
                end
                yv_d    = 1'b1;
                state_d = StOutB;
            end
            StOutB: begin
                y_d     = ctr_q;
                yv_d    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            for (int k = 0; k < 14; k++) begin
                d_q[k] <= '0;
            end
            for (int k = 0; k < 7; k++) begin
                p_q[k]    <= '0;
                prod_q[k] <= '0;
            end
            ctr_q <= '0;
            acc_q <= '0;
            y_q   <= '0;
            yv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            p_q     <= p_d;
            ctr_q   <= ctr_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

endmodule

// File: tb/tb_hb_interp2.sv
// Scoreboard bench for hb_interp2: driver pushes expected A/B per accept, monitor pops on each
// y_out_valid pulse. Directed vectors use hand-computed values; transients use a reference model.
module tb_hb_interp2;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] x_in;
    logic               x_in_valid;
    logic               x_in_ready;
    logic signed [15:0] y_out;
    logic               y_out_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int exp_q[$];
    int md[14];
    int cm[7] = '{3, -25, 117, -394, 1078, -2753, 10165};
    int tab_a[14] = '{3, -25, 117, -394, 1078, -2753, 10165, 10165, -2753, 1078, -394, 117, -25, 3};
    bit sat_pat[14] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1};

    hb_interp2 #(.DW(16), .ACCW(36)) dut (
        .clk        (clk),
        .reset      (reset),
        .x_in       (x_in),
        .x_in_valid (x_in_valid),
        .x_in_ready (x_in_ready),
        .y_out      (y_out),
        .y_out_valid(y_out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && y_out_valid) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got=%0d required=no_pulse", y_out);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(y_out) != e) begin
                    errors++;
                    $display("FAIL scoreboard got=%0d required=%0d", y_out, e);
                end
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Reference: plain multiplies on the full 14-sample window.
    task automatic model_step(input int v, output int ea, output int eb);
        longint acc;
        for (int k = 13; k > 0; k--) md[k] = md[k-1];
        md[0] = v;
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            acc += longint'(cm[k]) * (longint'(md[k]) + longint'(md[13-k]));
        end
        acc = acc >>> 14;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        ea = int'(acc);
        eb = md[6];
    endtask

    task automatic send(input int v, input bit hand, input int ha, input int hb);
        int ea, eb, n;
        x_in = 16'(v);
        x_in_valid = 1'b1;
        n = 0;
        while (!x_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!x_in_ready) begin
            chk("accept_timeout", n, 0);
        end else begin
            @(posedge clk);
            model_step(v, ea, eb);
            exp_q.push_back(hand ? ha : ea);
            exp_q.push_back(hand ? hb : eb);
            @(negedge clk);
            acc_cyc = cyc;
        end
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        chk({name, "_y_out"}, y_out, 0);
        chk({name, "_y_out_valid"}, y_out_valid, 0);
        exp_q.delete();
        for (int k = 0; k < 14; k++) md[k] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({name, "_ready_after"}, x_in_ready, 1);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int prev, p0;
        reset = 1'b1;
        x_in = '0;
        x_in_valid = 1'b0;
        for (int k = 0; k < 14; k++) md[k] = 0;
        repeat (3) @(negedge clk);
        chk("reset_y_out", y_out, 0);
        chk("reset_y_out_valid", y_out_valid, 0);
        reset = 1'b0;
        #1;
        chk("reset_ready", x_in_ready, 1);
        @(negedge clk);

        // Impulse response
        for (int i = 0; i < 14; i++) begin
            send(i == 0 ? 16384 : 0, 1'b1, tab_a[i], i == 6 ? 16384 : 0);
        end
        x_in_valid = 1'b0;
        drain("impulse");

        // DC gain
        for (int i = 0; i < 20; i++) begin
            send(10000, i >= 13, 9998, 10000);
        end
        x_in_valid = 1'b0;
        drain("dc");

        // Reset mid-stream right after an A pulse
        send(10000, 1'b1, 9998, 10000);
        x_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        do_reset("reset_mid");
        for (int i = 0; i < 14; i++) send(0, 1'b1, 0, 0);
        x_in_valid = 1'b0;
        drain("post_reset_zero");

        // Saturation, positive then negative
        for (int i = 0; i < 14; i++) begin
            send(sat_pat[i] ? 32767 : -32768, i == 13, 32767, 32767);
        end
        for (int i = 0; i < 14; i++) begin
            send(sat_pat[i] ? -32768 : 32767, i == 13, -32768, -32768);
        end
        x_in_valid = 1'b0;
        drain("saturation");

        // Back-to-back with valid held high
        p0 = pulses;
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            send(i * 1111 - 6000, 1'b0, 0, 0);
            if (i > 0) chk("accept_interval", acc_cyc - prev, 6);
            prev = acc_cyc;
        end
        x_in_valid = 1'b0;
        drain("handshake");
        chk("pulses_per_accept", pulses - p0, 24);

        // Single accept: pulses only at E4 and E5
        send(777, 1'b0, 0, 0);
        x_in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("valid_at_e%0d", c), y_out_valid, (c == 4 || c == 5) ? 1 : 0);
            if (c == 4) chk("ready_at_e4", x_in_ready, 0);
            if (c == 5) chk("ready_at_e5", x_in_ready, 1);
        end
        drain("timing");

        // Reset at E2 suppresses both pulses
        send(1234, 1'b0, 0, 0);
        x_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        p0 = pulses;
        do_reset("reset_e2");
        repeat (8) @(negedge clk);
        chk("no_pulse_after_reset_e2", pulses - p0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hb_interp2.md
Name: hb_interp2

Overview:
- Halfband x2 interpolation filter; the upsampling counterpart of the halfband x2 decimator in the audio chain.
- Takes 16-bit signed Q15 samples at rate Fs and emits two samples per input at 2·Fs, using the same 27-tap halfband prototype in polyphase form.
- Multiplierless: constant coefficients implemented as shift-add.
- Sits between low-rate processing and the high-rate output path (e.g. DAC/PWM modulator).

Parameters:
- DW, 16, sample width in and out (Q15).
- ACCW, 36, accumulator width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- x_in  in  DW  signed input sample
- x_in_valid  in  1  input sample offered
- x_in_ready  out  1  block can accept; transfer when valid && ready on a rising edge
- y_out  out  DW  signed output sample
- y_out_valid  out  1  one-cycle pulse per output sample

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs clear: y_out=0, y_out_valid=0.
  - x_in_ready=1 once reset deasserts.
  - Delay line d[0..13] cleared to 0; FSM to IDLE; all pipeline registers cleared.
  - Reset mid-operation discards in-flight results; no output pulse follows.
- Coefficients (Q15, even-index prototype taps h[2k], symmetric):
  - c0..c6 = 3, -25, 117, -394, 1078, -2753, 10165; c13-k = ck.
  - Centre tap h[13] = 16384 (0.5).
- Delay line: on accept, d[0]←x_in and d[k]←d[k-1]. d[13] is the oldest sample.
- FSM states: IDLE, PAIR, MULT, ACC, OUT_A, OUT_B.
  - x_in_ready = (state==IDLE).
  - Accept moves to PAIR; each later state advances one state per clk; OUT_B returns to IDLE.
  - x_in_valid while not ready is ignored. Upstream holds data stable until accepted.
- Timing: with accept on edge E0:
  - PAIR (E1): p[k] = d[k] + d[13-k], k=0..6, 17-bit signed. Centre sample d[6] captured.
  - MULT (E2): products ck·p[k], built from shifts/adds, sign-extended to ACCW.
  - ACC (E3): acc = sum of 7 products.
  - OUT_A (E4): y_out = sat16(acc >>> 14), y_out_valid=1.
  - OUT_B (E5): y_out = captured d[6] (exact, gain 2·0.5=1), y_out_valid=1.
  - x_in_ready high again after E5. Throughput: one input per 6 clocks; two outputs per accepted input, never more or fewer.
- Arithmetic rules:
  - >>>14 folds in the interpolation gain of 2 (Q30→Q15, ×2).
  - Arithmetic right shift (floor); no rounding.
  - sat16 clamps to [-32768, 32767].
- Output order: A (interpolated point between d[7] and d[6]) then B (d[6]). This is chronological order.
- Startup: outputs are produced from the first accepted input; empty delay taps read as 0. No priming suppression.
- y_out holds its last value when y_out_valid=0.

Test Plan:
- Reset: assert reset mid-stream → y_out=0, y_out_valid=0 immediately. After release, x_in_ready=1; next 14 outputs after a zero input are all 0.
- Impulse: accept 16384, then 13 zeros → A outputs 3, -25, 117, -394, 1078, -2753, 10165, 10165, -2753, 1078, -394, 117, -25, 3. B outputs are 0 except the 7th, which is 16384.
- DC: constant 10000 for ≥14 inputs → steady A = 9998 (10000·16382>>>14), B = 10000.
- Saturation:
  - 14 inputs, oldest→newest, +32767/-32768 in sign pattern + - + - + - + + - + - + - + → final A = 32767.
  - Same pattern negated → A = -32768.
- Handshake: x_in_valid held high with a changing sample every accept → x_in_ready high 1 of every 6 cycles; exactly 2 y_out_valid pulses per accept, at E4 and E5.
- Timing: single accept at E0 → y_out_valid only at E4 and E5. Reset at E2 → no pulses at E4/E5.
